// File: rtl/fetch_stage.sv
// fetch_stage: RV32I fetch stage with a single-outstanding imem interface feeding the IF/ID registers.
module fetch_stage #(
  parameter int              BITS      = 32,
  parameter logic [BITS-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [BITS-1:0] HALT_INST = 32'h0000_0073,
  parameter logic [BITS-1:0] NOP_INST  = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            STALL,
  input  logic            LWCP_STALL,
  input  logic            ID_PC_SRC,
  input  logic [BITS-1:0] ID_TARGET_ADDR,
  output logic            IMEM_REQ,
  output logic [BITS-1:0] IMEM_ADDR,
  input  logic            IMEM_RVALID,
  input  logic [BITS-1:0] IMEM_RDATA,
  output logic [BITS-1:0] IF_ID_Inst,
  output logic [BITS-1:0] IF_ID_PC,
  output logic [BITS-1:0] IF_ID_PC_INC,
  output logic            IF_ID_HLT,
  output logic            IF_HALTED
);
  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_BUF, S_HALT} state_t;
  state_t          state;
  logic [BITS-1:0] req_pc, buf_q, pc_inc, data;
  logic            discard, hold, redir, accept, is_halt;
  always_comb begin
    hold      = STALL | LWCP_STALL;
    redir     = ID_PC_SRC & ~hold;
    pc_inc    = req_pc + BITS'(4);
    data      = (state == S_BUF) ? buf_q : IMEM_RDATA;
    is_halt   = (data == HALT_INST);
    accept    = ~hold & ~redir & (((state == S_WAIT) & IMEM_RVALID & ~discard) | (state == S_BUF));
    // a non-halt delivery immediately requests the next word, giving 1 inst/cycle with 1-cycle memory
    IMEM_REQ  = rst_n & (((state == S_ISSUE) & ~redir) | (accept & ~is_halt));
    IMEM_ADDR = (state == S_ISSUE) ? req_pc : pc_inc;
    IF_HALTED = (state == S_HALT);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_ISSUE;
      req_pc       <= RESET_VEC;
      discard      <= 1'b0;
      buf_q        <= NOP_INST;
      IF_ID_Inst   <= NOP_INST;
      IF_ID_PC     <= '0;
      IF_ID_PC_INC <= BITS'(4);
      IF_ID_HLT    <= 1'b0;
    end else begin
      if (accept) begin
        IF_ID_Inst   <= data;
        IF_ID_PC     <= req_pc;
        IF_ID_PC_INC <= pc_inc;
        IF_ID_HLT    <= is_halt;
        req_pc       <= pc_inc;
        state        <= is_halt ? S_HALT : S_WAIT;
      end else if (!hold) begin
        IF_ID_Inst   <= NOP_INST;
        IF_ID_PC     <= '0;
        IF_ID_PC_INC <= BITS'(4);
        IF_ID_HLT    <= 1'b0;
      end
      if (redir) req_pc <= ID_TARGET_ADDR;
      // non-accept transitions; an in-flight response after a redirect is dropped via discard
      case (state)
        S_ISSUE: if (!redir) state <= S_WAIT;
        S_WAIT: begin
          if (IMEM_RVALID && (discard || redir)) begin
            discard <= 1'b0;
            state   <= S_ISSUE;
          end else if (IMEM_RVALID && hold) begin
            buf_q <= IMEM_RDATA;
            state <= S_BUF;
          end else if (redir) begin
            discard <= 1'b1;
          end
        end
        S_BUF, S_HALT: if (redir) state <= S_ISSUE;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with a variable-latency instruction memory model.
module tb_fetch_stage;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'h0000_0073;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inc;
    logic [31:0] inst;
    logic        hlt;
  } item_t;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        STALL = 1'b0, LWCP_STALL = 1'b0, ID_PC_SRC = 1'b0;
  logic [31:0] ID_TARGET_ADDR = '0;
  logic        IMEM_REQ, IMEM_RVALID = 1'b0;
  logic [31:0] IMEM_ADDR, IMEM_RDATA = '0;
  logic [31:0] IF_ID_Inst, IF_ID_PC, IF_ID_PC_INC;
  logic        IF_ID_HLT, IF_HALTED;
  int          n_chk = 0, n_err = 0;
  int          cyc = 0, lat = 1, resp_cyc = 0, req_cnt = 0, n_deliv = 0, last_cyc = 0, last_gap = 0;
  logic        pend = 1'b0, hold_prev = 1'b0, exp_halted = 1'b0, no_req = 1'b0;
  logic [31:0] pend_addr = '0, next_req = '0;
  item_t       exp_q[$];
  item_t       cur;
  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .STALL(STALL), .LWCP_STALL(LWCP_STALL),
    .ID_PC_SRC(ID_PC_SRC), .ID_TARGET_ADDR(ID_TARGET_ADDR),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
    .IF_ID_Inst(IF_ID_Inst), .IF_ID_PC(IF_ID_PC), .IF_ID_PC_INC(IF_ID_PC_INC),
    .IF_ID_HLT(IF_ID_HLT), .IF_HALTED(IF_HALTED)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h40) return HALT;
    if (a == 32'h10) return 32'h0050_0093;
    return {a[11:0], 20'h00093};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic observe();
    item_t e;
    if (hold_prev) begin
      chk("hold_inst", IF_ID_Inst, cur.inst);
      chk("hold_pc", IF_ID_PC, cur.pc);
      chk("hold_hlt", IF_ID_HLT, cur.hlt);
    end else if (IF_ID_Inst != NOP) begin
      if (exp_q.size() == 0) chk("extra_out", IF_ID_Inst, NOP);
      else begin
        e = exp_q.pop_front();
        chk("out_inst", IF_ID_Inst, e.inst);
        chk("out_pc", IF_ID_PC, e.pc);
        chk("out_pc_inc", IF_ID_PC_INC, e.inc);
        chk("out_hlt", IF_ID_HLT, e.hlt);
        cur = e;
        last_gap = cyc - last_cyc;
        last_cyc = cyc;
        n_deliv++;
        if (e.hlt) exp_halted = 1'b1;
      end
    end else begin
      chk("bubble_pc", IF_ID_PC, 32'h0);
      chk("bubble_pc_inc", IF_ID_PC_INC, 32'h4);
      chk("bubble_hlt", IF_ID_HLT, 32'h0);
      cur = '{pc: 32'h0, inc: 32'h4, inst: NOP, hlt: 1'b0};
    end
    chk("halted", IF_HALTED, exp_halted);
  endtask
  // drive one cycle's inputs at a negedge, model memory, then observe the next IF/ID state
  task automatic tick(input logic st, input logic lws, input logic ps, input logic [31:0] tg);
    item_t e;
    STALL = st;
    LWCP_STALL = lws;
    ID_PC_SRC = ps;
    ID_TARGET_ADDR = tg;
    if (ps && !(st || lws)) begin
      exp_q.delete();
      next_req = tg;
      exp_halted = 1'b0;
      no_req = 1'b0;
    end
    if (pend && cyc == resp_cyc) begin
      IMEM_RVALID = 1'b1;
      IMEM_RDATA = mem_rd(pend_addr);
      pend = 1'b0;
    end else begin
      IMEM_RVALID = 1'b0;
      IMEM_RDATA = $urandom;
    end
    #1;
    if (IMEM_REQ) begin
      req_cnt++;
      chk("req_single", pend, 32'h0);
      chk("req_after_halt", no_req, 32'h0);
      chk("req_addr", IMEM_ADDR, next_req);
      e = '{pc: next_req, inc: next_req + 32'h4, inst: mem_rd(next_req), hlt: mem_rd(next_req) == HALT};
      exp_q.push_back(e);
      if (e.hlt) no_req = 1'b1;
      next_req += 32'h4;
      pend = 1'b1;
      pend_addr = IMEM_ADDR;
      resp_cyc = cyc + lat;
    end
    hold_prev = st | lws;
    @(negedge clk);
    cyc++;
    observe();
  endtask
  task automatic wait_pop(input int n);
    int target;
    target = n_deliv + n;
    for (int i = 0; i < 60 && n_deliv < target; i++) tick(1'b0, 1'b0, 1'b0, 32'h0);
    if (n_deliv < target) chk("deliver_timeout", n_deliv, target);
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    STALL = 1'b0;
    LWCP_STALL = 1'b0;
    ID_PC_SRC = 1'b0;
    IMEM_RVALID = 1'b0;
    pend = 1'b0;
    exp_q.delete();
    next_req = 32'h0;
    exp_halted = 1'b0;
    no_req = 1'b0;
    hold_prev = 1'b0;
    cur = '{pc: 32'h0, inc: 32'h4, inst: NOP, hlt: 1'b0};
    #1;
    chk("rst_req", IMEM_REQ, 32'h0);
    chk("rst_inst", IF_ID_Inst, NOP);
    chk("rst_pc", IF_ID_PC, 32'h0);
    chk("rst_pc_inc", IF_ID_PC_INC, 32'h4);
    chk("rst_hlt", IF_ID_HLT, 32'h0);
    chk("rst_halted", IF_HALTED, 32'h0);
    @(negedge clk);
    chk("rst_hold_inst", IF_ID_Inst, NOP);
    rst_n = 1'b1;
  endtask
  initial begin
    int rc;
    do_reset();
    rc = req_cnt;
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    chk("first_req_after_reset", req_cnt - rc, 32'h1);
    // 1-cycle memory: back-to-back delivery of 0x0..0xC
    wait_pop(4);
    chk("gap_lat1", last_gap, 32'h1);
    chk("pc_0xC", IF_ID_PC, 32'hC);
    // response for 0x10 lands under STALL then LWCP_STALL
    rc = req_cnt;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    chk("no_req_while_stalled", req_cnt - rc, 32'h0);
    lat = 4;
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    chk("stall_release_pc", IF_ID_PC, 32'h10);
    chk("stall_release_inst", IF_ID_Inst, 32'h0050_0093);
    chk("req_after_release", req_cnt - rc, 32'h1);
    // slow memory: one instruction every four cycles
    wait_pop(3);
    chk("gap_slow", last_gap, 32'h4);
    // redirect twice while 0x20 is outstanding; final target wins
    tick(1'b0, 1'b0, 1'b1, 32'h300);
    tick(1'b0, 1'b0, 1'b1, 32'h100);
    wait_pop(1);
    chk("redir_pc", IF_ID_PC, 32'h100);
    // redirect during stall is ignored
    tick(1'b1, 1'b0, 1'b1, 32'h200);
    wait_pop(1);
    chk("stalled_redir_ignored", IF_ID_PC, 32'h104);
    // jump to the halt instruction
    lat = 1;
    tick(1'b0, 1'b0, 1'b1, 32'h40);
    wait_pop(1);
    chk("halt_hlt", IF_ID_HLT, 32'h1);
    chk("halt_pc", IF_ID_PC, 32'h40);
    chk("halt_state", IF_HALTED, 32'h1);
    rc = req_cnt;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    chk("halt_held", IF_ID_HLT, 32'h1);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    chk("halt_no_req", req_cnt - rc, 32'h0);
    chk("halt_stays", IF_HALTED, 32'h1);
    tick(1'b0, 1'b0, 1'b1, 32'h80);
    chk("halt_left", IF_HALTED, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    chk("req_after_unhalt", req_cnt - rc, 32'h1);
    wait_pop(1);
    chk("unhalt_pc", IF_ID_PC, 32'h80);
    // asynchronous reset while 0x84 is outstanding
    do_reset();
    rc = req_cnt;
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    chk("req_after_mid_reset", req_cnt - rc, 32'h1);
    wait_pop(2);
    chk("post_reset_pc", IF_ID_PC, 32'h4);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
